// File: rtl/hp_manager_if.sv
// Hit-point manager bus: round control, hit pulses in, HP/status out.
// Latency: n/a (signal bundle only).
// Backpressure: none; all inputs are single-cycle pulses or levels.
//
// master : game logic side (drives frame_clk, start, hits, damage)
// slave  : hp_manager side (drives HP bars, invulnerability, game result)
interface hp_manager_if;
   logic       frame_clk;
   logic       start;
   logic       ship1_hit;
   logic [7:0] ship1_dmg;
   logic       ship2_hit;
   logic [7:0] ship2_dmg;
   logic [9:0] ship1_hp;
   logic [9:0] ship2_hp;
   logic       ship1_invuln;
   logic       ship2_invuln;
   logic       game_over;
   logic [1:0] winner;

   modport master (
      output frame_clk, start, ship1_hit, ship1_dmg, ship2_hit, ship2_dmg,
      input  ship1_hp, ship2_hp, ship1_invuln, ship2_invuln, game_over, winner
   );

   modport slave (
      input  frame_clk, start, ship1_hit, ship1_dmg, ship2_hit, ship2_dmg,
      output ship1_hp, ship2_hp, ship1_invuln, ship2_invuln, game_over, winner
   );
endinterface

// File: rtl/hp_manager.sv
// Per-ship HP keeper: damage, invulnerability/regeneration timers, win detection.
// Latency: hits visible on HP one cycle later; timers step 1 cycle after registered frame_clk rises.
// Backpressure: none; every input pulse is consumed in the cycle it arrives.
//
// Ports:
//   Clk, Reset_n : clock, asynchronous active-low reset
//   bus (slave)  : frame_clk/start/hit/dmg in; ship*_hp, ship*_invuln, game_over, winner out
module hp_manager #(
   parameter logic [9:0] MAX_HP        = 10'd200,
   parameter logic [7:0] INVULN_FRAMES = 8'd30,
   parameter logic [7:0] REGEN_FRAMES  = 8'd60
) (
   input  logic         Clk,
   input  logic         Reset_n,
   hp_manager_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      OVER = 2'd2
   } state_t;

   state_t     state_q;
   logic       game_over_q;
   logic [1:0] winner_q;

   logic       frame_q, frame_q2;
   logic       frame_tick;

   logic [9:0] hp_q   [2];
   logic [9:0] hp_d   [2];
   logic [7:0] inv_q  [2];
   logic [7:0] inv_d  [2];
   logic [7:0] rg_q   [2];
   logic [7:0] rg_d   [2];

   logic       hit_w  [2];
   logic [9:0] dmg_w  [2];

   logic       any_zero;
   logic       reload;
   logic       play_upd;

   assign hit_w[0] = bus.ship1_hit;
   assign hit_w[1] = bus.ship2_hit;
   assign dmg_w[0] = {2'b00, bus.ship1_dmg};
   assign dmg_w[1] = {2'b00, bus.ship2_dmg};

   // Tick on the rising edge of the registered frame_clk.
   assign frame_tick = frame_q & ~frame_q2;

   assign any_zero = (hp_q[0] == 10'd0) || (hp_q[1] == 10'd0);
   assign reload   = (state_q != PLAY) && bus.start;
   // The PLAY->OVER transition cycle freezes HP so the result matches the HP that ended the round.
   assign play_upd = (state_q == PLAY) && !any_zero;

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         hp_d[i]  = hp_q[i];
         inv_d[i] = inv_q[i];
         rg_d[i]  = rg_q[i];
         if (reload) begin
            hp_d[i]  = MAX_HP;
            inv_d[i] = 8'd0;
            rg_d[i]  = 8'd0;
         end else if (play_upd && hit_w[i] && (inv_q[i] == 8'd0)) begin
            // Accepted hit overrides any regen step on the same tick.
            hp_d[i]  = (hp_q[i] > dmg_w[i]) ? (hp_q[i] - dmg_w[i]) : 10'd0;
            inv_d[i] = INVULN_FRAMES;
            rg_d[i]  = 8'd0;
         end else begin
            if (frame_tick && (inv_q[i] != 8'd0)) begin
               inv_d[i] = inv_q[i] - 8'd1;
            end
            if (play_upd && frame_tick && (hp_q[i] != 10'd0) && (hp_q[i] < MAX_HP)) begin
               if (rg_q[i] == (REGEN_FRAMES - 8'd1)) begin
                  hp_d[i] = hp_q[i] + 10'd1;
                  rg_d[i] = 8'd0;
               end else begin
                  rg_d[i] = rg_q[i] + 8'd1;
               end
            end
         end
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         frame_q  <= 1'b0;
         frame_q2 <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            hp_q[i]  <= MAX_HP;
            inv_q[i] <= 8'd0;
            rg_q[i]  <= 8'd0;
         end
      end else begin
         frame_q  <= bus.frame_clk;
         frame_q2 <= frame_q;
         for (int i = 0; i < 2; i++) begin
            hp_q[i]  <= hp_d[i];
            inv_q[i] <= inv_d[i];
            rg_q[i]  <= rg_d[i];
         end
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q     <= IDLE;
         game_over_q <= 1'b0;
         winner_q    <= 2'b00;
      end else begin
         case (state_q)
            IDLE, OVER: begin
               if (bus.start) begin
                  state_q     <= PLAY;
                  game_over_q <= 1'b0;
                  winner_q    <= 2'b00;
               end
            end
            PLAY: begin
               if (any_zero) begin
                  state_q     <= OVER;
                  game_over_q <= 1'b1;
                  // bit1: ship1 dead (ship2 wins), bit0: ship2 dead (ship1 wins)
                  winner_q    <= {hp_q[0] == 10'd0, hp_q[1] == 10'd0};
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.ship1_hp     = hp_q[0];
   assign bus.ship2_hp     = hp_q[1];
   assign bus.ship1_invuln = (inv_q[0] != 8'd0);
   assign bus.ship2_invuln = (inv_q[1] != 8'd0);
   assign bus.game_over    = game_over_q;
   assign bus.winner       = winner_q;

endmodule

// File: tb/tb_hp_manager.sv
// Bench for hp_manager: directed scenarios plus random traffic against a round-level model.
// Latency: expectations pushed when inputs are driven, compared one edge later.
// Backpressure: n/a.
module tb_hp_manager;

   logic clk;
   logic rst_n;

   hp_manager_if bus ();

   hp_manager dut (
      .Clk     (clk),
      .Reset_n (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [9:0] h1;
      logic [9:0] h2;
      logic       i1;
      logic       i2;
      logic       go;
      logic [1:0] w;
   } exp_t;

   exp_t exp_q[$];

   int checks = 0;
   int errors = 0;

   // Round-level model
   int m_hp  [2];
   int m_inv [2];
   int m_rg  [2];
   int m_win;
   bit m_go;
   bit m_play;
   bit fc_last, fc_prev;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < 2; i++) begin
         m_hp[i]  = 200;
         m_inv[i] = 0;
         m_rg[i]  = 0;
      end
      m_win   = 0;
      m_go    = 1'b0;
      m_play  = 1'b0;
      fc_last = 1'b0;
      fc_prev = 1'b0;
   endfunction

   function automatic void model_step(input bit st, input bit h1, input int d1,
                                      input bit h2, input int d2, input bit fc);
      bit tick;
      bit hit [2];
      int dmg [2];
      tick    = fc_last && !fc_prev;
      fc_prev = fc_last;
      fc_last = fc;
      hit[0] = h1; hit[1] = h2;
      dmg[0] = d1; dmg[1] = d2;
      if (!m_play) begin
         if (st) begin
            for (int i = 0; i < 2; i++) begin
               m_hp[i] = 200; m_inv[i] = 0; m_rg[i] = 0;
            end
            m_win = 0; m_go = 1'b0; m_play = 1'b1;
         end else begin
            for (int i = 0; i < 2; i++) if (tick && m_inv[i] > 0) m_inv[i]--;
         end
      end else if (m_hp[0] == 0 || m_hp[1] == 0) begin
         m_play = 1'b0;
         m_go   = 1'b1;
         m_win  = ((m_hp[1] == 0) ? 1 : 0) + ((m_hp[0] == 0) ? 2 : 0);
         for (int i = 0; i < 2; i++) if (tick && m_inv[i] > 0) m_inv[i]--;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (hit[i] && m_inv[i] == 0) begin
               m_hp[i]  = (m_hp[i] > dmg[i]) ? m_hp[i] - dmg[i] : 0;
               m_inv[i] = 30;
               m_rg[i]  = 0;
            end else if (tick) begin
               if (m_inv[i] > 0) m_inv[i]--;
               if (m_hp[i] > 0 && m_hp[i] < 200) begin
                  m_rg[i]++;
                  if (m_rg[i] == 60) begin
                     m_hp[i]++;
                     m_rg[i] = 0;
                  end
               end
            end
         end
      end
   endfunction

   function automatic exp_t model_out();
      exp_t e;
      e.h1 = m_hp[0][9:0];
      e.h2 = m_hp[1][9:0];
      e.i1 = (m_inv[0] != 0);
      e.i2 = (m_inv[1] != 0);
      e.go = m_go;
      e.w  = m_win[1:0];
      return e;
   endfunction

   // Drive one cycle of inputs (called at a negedge), returns at the next negedge.
   task automatic cycle(input bit st, input bit h1, input int d1,
                        input bit h2, input int d2, input bit fc);
      bus.start     = st;
      bus.ship1_hit = h1;
      bus.ship1_dmg = d1[7:0];
      bus.ship2_hit = h2;
      bus.ship2_dmg = d2[7:0];
      bus.frame_clk = fc;
      model_step(st, h1, d1, h2, d2, fc);
      exp_q.push_back(model_out());
      @(negedge clk);
   endtask

   // One frame: frame_clk high then low; the tick lands in the second cycle, with the hits.
   task automatic frame(input bit h1, input int d1, input bit h2, input int d2);
      cycle(1'b0, 1'b0, 0, 1'b0, 0, 1'b1);
      cycle(1'b0, h1, d1, h2, d2, 1'b0);
   endtask

   task automatic frames(input int n);
      for (int k = 0; k < n; k++) frame(1'b0, 0, 1'b0, 0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_s1hp"}, bus.ship1_hp, 200);
      chk({tag, "_s2hp"}, bus.ship2_hp, 200);
      chk({tag, "_s1inv"}, bus.ship1_invuln, 0);
      chk({tag, "_s2inv"}, bus.ship2_invuln, 0);
      chk({tag, "_go"}, bus.game_over, 0);
      chk({tag, "_win"}, bus.winner, 0);
   endtask

   // Monitor: compares DUT against the queued expectation after every edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("mon_s1hp", bus.ship1_hp, e.h1);
            chk("mon_s2hp", bus.ship2_hp, e.h2);
            chk("mon_s1inv", bus.ship1_invuln, e.i1);
            chk("mon_s2inv", bus.ship2_invuln, e.i2);
            chk("mon_go", bus.game_over, e.go);
            chk("mon_win", bus.winner, e.w);
         end
      end
   end

   initial begin
      bit st, h1, h2, fc;
      int d1, d2;
      rst_n = 1'b0;
      bus.start = 1'b0; bus.frame_clk = 1'b0;
      bus.ship1_hit = 1'b0; bus.ship1_dmg = 8'd0;
      bus.ship2_hit = 1'b0; bus.ship2_dmg = 8'd0;
      model_reset();
      repeat (3) @(negedge clk);
      chk_reset_vals("reset");
      rst_n = 1'b1;

      // Idle: hits ignored before start
      cycle(1'b0, 1'b1, 50, 1'b1, 50, 1'b0);
      cycle(1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
      chk("idle_hit_ignored", bus.ship1_hp, 200);

      // First hit
      cycle(1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
      cycle(1'b0, 1'b1, 50, 1'b0, 0, 1'b0);
      chk("hit50_s1hp", bus.ship1_hp, 150);
      chk("hit50_s1inv", bus.ship1_invuln, 1);
      chk("hit50_s2hp", bus.ship2_hp, 200);

      // Invulnerability window: four more hits during 30 ticks are ignored
      for (int f = 0; f < 30; f++) begin
         if (f == 0 || f == 7 || f == 14 || f == 28) frame(1'b1, 50, 1'b0, 0);
         else frame(1'b0, 0, 1'b0, 0);
      end
      chk("inv_window_s1hp", bus.ship1_hp, 150);
      chk("inv_expired", bus.ship1_invuln, 0);
      cycle(1'b0, 1'b1, 50, 1'b0, 0, 1'b0);
      chk("hit_after_inv", bus.ship1_hp, 100);

      // Regeneration on ship 2
      cycle(1'b0, 1'b0, 0, 1'b1, 10, 1'b0);
      chk("s2_190", bus.ship2_hp, 190);
      frames(60);
      chk("regen_60", bus.ship2_hp, 191);
      frames(540);
      chk("regen_600", bus.ship2_hp, 200);
      frames(100);
      chk("regen_cap", bus.ship2_hp, 200);

      // Ship 1 wins
      cycle(1'b0, 1'b0, 0, 1'b1, 180, 1'b0);
      chk("s2_20", bus.ship2_hp, 20);
      frames(30);
      cycle(1'b0, 1'b0, 0, 1'b1, 255, 1'b0);
      chk("s2_zero", bus.ship2_hp, 0);
      chk("go_not_yet", bus.game_over, 0);
      cycle(1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
      chk("s1win_go", bus.game_over, 1);
      chk("s1win_w", bus.winner, 1);
      for (int k = 0; k < 5; k++) frame(1'b1, 7, 1'b1, 7);
      chk("over_s2_frozen", bus.ship2_hp, 0);
      chk("over_s1_frozen", bus.ship1_hp, m_hp[0]);
      chk("over_w_hold", bus.winner, 1);

      // Draw, then restart
      cycle(1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
      chk_reset_vals("restart1");
      cycle(1'b0, 1'b1, 190, 1'b1, 190, 1'b0);
      chk("draw_s1_10", bus.ship1_hp, 10);
      frames(30);
      cycle(1'b0, 1'b1, 10, 1'b1, 10, 1'b0);
      cycle(1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
      chk("draw_w", bus.winner, 3);
      chk("draw_go", bus.game_over, 1);
      cycle(1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
      chk_reset_vals("restart2");

      // Hit coinciding with the regen tick
      cycle(1'b0, 1'b1, 50, 1'b0, 0, 1'b0);
      frames(59);
      chk("pre_regen", bus.ship1_hp, 150);
      frame(1'b1, 5, 1'b0, 0);
      chk("hit_beats_regen", bus.ship1_hp, 145);
      frames(59);
      chk("regen_restarted", bus.ship1_hp, 145);
      frames(1);
      chk("regen_after_restart", bus.ship1_hp, 146);

      // Asynchronous reset mid-round
      cycle(1'b0, 1'b0, 0, 1'b1, 30, 1'b0);
      rst_n = 1'b0;
      #1;
      chk_reset_vals("async_rst");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;

      // Random traffic
      for (int n = 0; n < 4000; n++) begin
         st = (!m_play && ($urandom_range(0, 9) == 0)) || ($urandom_range(0, 299) == 0);
         h1 = ($urandom_range(0, 5) == 0);
         h2 = ($urandom_range(0, 5) == 0);
         d1 = ($urandom_range(0, 3) == 0) ? $urandom_range(100, 255) : $urandom_range(0, 40);
         d2 = ($urandom_range(0, 3) == 0) ? $urandom_range(100, 255) : $urandom_range(0, 40);
         fc = $urandom_range(0, 1);
         cycle(st, h1, d1, h2, d2, fc);
      end

      cycle(1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
      @(negedge clk);
      chk("queue_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
